// File: rtl/uart_wb_master.sv
// uart_wb_master
//   Bridges a host serial link to a single-master Wishbone bus. The host sends
//   command frames; the bridge runs one classic Wishbone cycle per frame and
//   sends back a status or data reply. Serial format is 8N1, and only one
//   transaction is outstanding at a time.
//
//   Frames (multi-byte fields MSB first):
//     write : 'W'(0x57) A3 A2 A1 A0 D3 D2 D1 D0 -> 'K'(0x4B) on ack, 'E'(0x45) on timeout
//     read  : 'R'(0x52) A3 A2 A1 A0             -> D3 D2 D1 D0 on ack, 'E' on timeout
//     A byte other than 'W' or 'R' that arrives while idle is ignored.
//
// Parameters
//   CLKS_PER_BIT : clock cycles per serial bit (must be >= 4)
//   ACK_TIMEOUT  : cycles that cyc/stb stay high without an ack before the cycle is aborted
//
// Ports
//   wb_clk_i  : clock, all logic on the rising edge
//   wb_rst_i  : synchronous active-high reset
//   uart_rx   : asynchronous serial input, idle high
//   uart_tx   : serial output, idle high
//   wbm_*     : Wishbone master (cyc, stb, we, sel, adr, dat out; dat in, ack in)
//   busy_o    : high from the accepted command byte until the last reply stop bit

module uart_wb_master #(
  parameter int CLKS_PER_BIT = 87,
  parameter int ACK_TIMEOUT  = 1024
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        uart_rx,
  output logic        uart_tx,
  output logic        wbm_cyc_o,
  output logic        wbm_stb_o,
  output logic        wbm_we_o,
  output logic [3:0]  wbm_sel_o,
  output logic [31:0] wbm_adr_o,
  output logic [31:0] wbm_dat_o,
  input  logic [31:0] wbm_dat_i,
  input  logic        wbm_ack_i,
  output logic        busy_o
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(ACK_TIMEOUT - 1);

  localparam logic [7:0] CMD_W  = 8'h57;
  localparam logic [7:0] CMD_R  = 8'h52;
  localparam logic [7:0] RESP_K = 8'h4B;
  localparam logic [7:0] RESP_E = 8'h45;

  // ---------------------------------------------------------------------------
  // Serial receiver
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  rx_state_t       rx_state;
  logic            rx_s1, rx_s2, rx_s3;
  logic [CW-1:0]   rx_cnt;
  logic [2:0]      rx_bitn;
  logic [7:0]      rx_shift;
  logic            rx_valid;
  logic            rx_ferr;

  // rx_s1/rx_s2 synchronise the pin, and rx_s3 holds the previous value so
  // that only a true high-to-low transition starts a frame. A line held low
  // after a framing error therefore cannot retrigger. The start bit is checked
  // again half a bit later, which rejects short glitches. rx_shift stays
  // stable while idle, so it is the received byte during the rx_valid pulse.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rx_state <= RX_IDLE;
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_s3    <= 1'b1;
      rx_cnt   <= '0;
      rx_bitn  <= '0;
      rx_shift <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= uart_rx;
      rx_s2    <= rx_s1;
      rx_s3    <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (rx_s3 && !rx_s2) begin
            rx_state <= RX_START;
            rx_cnt   <= '0;
          end
        end
        RX_START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= '0;
            rx_bitn  <= '0;
            rx_state <= rx_s2 ? RX_IDLE : RX_DATA;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bitn  <= rx_bitn + 3'd1;
            if (rx_bitn == 3'd7) rx_state <= RX_STOP;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_state <= RX_IDLE;
            if (rx_s2) rx_valid <= 1'b1;
            else       rx_ferr  <= 1'b1;
          end else begin
            rx_cnt <= rx_cnt + CW'(1);
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Serial transmitter
  // ---------------------------------------------------------------------------
  logic          tx_start;
  logic [7:0]    tx_data;
  logic          tx_active;
  logic [8:0]    tx_shift;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bitn;
  logic          tx_done;

  // tx_done marks the final cycle of the stop bit. The command FSM can then
  // queue the next reply byte so that it starts right after the stop bit.
  assign tx_done = tx_active && (tx_bitn == 4'd9) && (tx_cnt == BIT_LAST);

  // The start bit goes out as soon as tx_start is taken. tx_shift then holds
  // the data bits followed by the stop bit, and they shift out LSB first.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      uart_tx   <= 1'b1;
      tx_active <= 1'b0;
      tx_shift  <= '1;
      tx_cnt    <= '0;
      tx_bitn   <= '0;
    end else if (!tx_active) begin
      uart_tx <= 1'b1;
      if (tx_start) begin
        tx_active <= 1'b1;
        uart_tx   <= 1'b0;
        tx_shift  <= {1'b1, tx_data};
        tx_cnt    <= '0;
        tx_bitn   <= '0;
      end
    end else if (tx_cnt == BIT_LAST) begin
      tx_cnt <= '0;
      if (tx_bitn == 4'd9) begin
        tx_active <= 1'b0;
        uart_tx   <= 1'b1;
      end else begin
        uart_tx  <= tx_shift[0];
        tx_shift <= {1'b1, tx_shift[8:1]};
        tx_bitn  <= tx_bitn + 4'd1;
      end
    end else begin
      tx_cnt <= tx_cnt + CW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM and Wishbone master
  // ---------------------------------------------------------------------------
  typedef enum logic [2:0] {IDLE, GET_ADDR, GET_DATA, WB_REQ, SEND_RESP} state_t;

  state_t        state;
  logic          is_write;
  logic [1:0]    byte_cnt;
  logic [31:0]   addr_sh;
  logic [31:0]   data_sh;
  logic [31:0]   resp_buf;
  logic [2:0]    resp_left;
  logic [TW-1:0] tmo_cnt;

  // Address and data bytes collect in shadow registers. The bus outputs change
  // only when a cycle is launched, and they keep their values afterwards.
  // Bytes that arrive during WB_REQ or SEND_RESP are dropped. A framing error
  // abandons a partially received frame. The timeout counter runs from the
  // first cycle of cyc, and an ack in the limit cycle still counts as success.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      is_write  <= 1'b0;
      byte_cnt  <= '0;
      addr_sh   <= '0;
      data_sh   <= '0;
      resp_buf  <= '0;
      resp_left <= '0;
      tmo_cnt   <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_sel_o <= 4'h0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      busy_o    <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_valid && (rx_shift == CMD_W || rx_shift == CMD_R)) begin
            is_write <= (rx_shift == CMD_W);
            byte_cnt <= '0;
            busy_o   <= 1'b1;
            state    <= GET_ADDR;
          end
        end
        GET_ADDR: begin
          if (rx_ferr) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (rx_valid) begin
            addr_sh  <= {addr_sh[23:0], rx_shift};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              if (is_write) begin
                state <= GET_DATA;
              end else begin
                wbm_adr_o <= {addr_sh[23:0], rx_shift};
                wbm_we_o  <= 1'b0;
                wbm_sel_o <= 4'hF;
                wbm_cyc_o <= 1'b1;
                wbm_stb_o <= 1'b1;
                tmo_cnt   <= '0;
                state     <= WB_REQ;
              end
            end
          end
        end
        GET_DATA: begin
          if (rx_ferr) begin
            busy_o <= 1'b0;
            state  <= IDLE;
          end else if (rx_valid) begin
            data_sh  <= {data_sh[23:0], rx_shift};
            byte_cnt <= byte_cnt + 2'd1;
            if (byte_cnt == 2'd3) begin
              wbm_adr_o <= addr_sh;
              wbm_dat_o <= {data_sh[23:0], rx_shift};
              wbm_we_o  <= 1'b1;
              wbm_sel_o <= 4'hF;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
              tmo_cnt   <= '0;
              state     <= WB_REQ;
            end
          end
        end
        WB_REQ: begin
          if (wbm_ack_i) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            tx_start  <= 1'b1;
            state     <= SEND_RESP;
            if (wbm_we_o) begin
              tx_data   <= RESP_K;
              resp_left <= 3'd1;
            end else begin
              tx_data   <= wbm_dat_i[31:24];
              resp_buf  <= {wbm_dat_i[23:0], 8'h00};
              resp_left <= 3'd4;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            tx_start  <= 1'b1;
            tx_data   <= RESP_E;
            resp_left <= 3'd1;
            state     <= SEND_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        SEND_RESP: begin
          if (tx_done) begin
            if (resp_left == 3'd1) begin
              busy_o <= 1'b0;
              state  <= IDLE;
            end else begin
              resp_left <= resp_left - 3'd1;
              tx_start  <= 1'b1;
              tx_data   <= resp_buf[31:24];
              resp_buf  <= {resp_buf[23:0], 8'h00};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_wb_master.sv
// tb_uart_wb_master
//   Self-checking bench for uart_wb_master. It drives serial command frames,
//   runs a behavioural Wishbone slave, and decodes the serial replies. Results
//   are compared against a frame-level reference model.

module tb_uart_wb_master;

  localparam int CPB = 8;
  localparam int ATO = 64;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i;
  logic        uart_rx;
  logic        uart_tx;
  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;
  logic        busy_o;

  int errors = 0;
  int checks = 0;

  uart_wb_master #(.CLKS_PER_BIT(CPB), .ACK_TIMEOUT(ATO)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .uart_rx  (uart_rx),
    .uart_tx  (uart_tx),
    .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o),
    .wbm_we_o (wbm_we_o),
    .wbm_sel_o(wbm_sel_o),
    .wbm_adr_o(wbm_adr_o),
    .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i),
    .busy_o   (busy_o)
  );

  always #5 wb_clk_i = ~wb_clk_i;

  // Wishbone slave: records each bus cycle (its fields, length, and whether the
  // fields stayed stable) and acks after ack_delay wait cycles when enabled.
  // Non-ack cycles present random read data.
  typedef struct {
    logic [31:0] adr;
    logic [31:0] dat;
    logic        we;
    logic [3:0]  sel;
    int          len;
    bit          stable;
  } wb_txn_t;

  wb_txn_t     txn_q[$];
  wb_txn_t     cur;
  int          cyc_run = 0;
  bit          ack_en = 1'b1;
  int          ack_delay = 0;
  logic [31:0] slave_rdata = '0;

  always @(negedge wb_clk_i) begin
    if (wbm_cyc_o) begin
      cyc_run++;
      if (cyc_run == 1) begin
        cur.adr    = wbm_adr_o;
        cur.dat    = wbm_dat_o;
        cur.we     = wbm_we_o;
        cur.sel    = wbm_sel_o;
        cur.stable = (wbm_stb_o === 1'b1);
      end else if (wbm_adr_o !== cur.adr || wbm_dat_o !== cur.dat ||
                   wbm_we_o !== cur.we || wbm_sel_o !== cur.sel || wbm_stb_o !== 1'b1) begin
        cur.stable = 1'b0;
      end
      wbm_ack_i = ack_en && (cyc_run == ack_delay + 1);
      wbm_dat_i = wbm_ack_i ? slave_rdata : $urandom;
    end else begin
      if (cyc_run != 0) begin
        cur.len = cyc_run;
        txn_q.push_back(cur);
      end
      cyc_run   = 0;
      wbm_ack_i = 1'b0;
    end
  end

  // Serial monitor: decodes each byte the DUT transmits, sampling mid-bit.
  logic [7:0] reply_q[$];
  logic [7:0] mon_byte;
  logic       mon_prev = 1'b1;
  int         tx_ferr = 0;

  always begin
    @(negedge wb_clk_i);
    if (mon_prev === 1'b1 && uart_tx === 1'b0) begin
      repeat (CPB / 2) @(negedge wb_clk_i);
      if (uart_tx === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge wb_clk_i);
          mon_byte[i] = uart_tx;
        end
        repeat (CPB) @(negedge wb_clk_i);
        if (uart_tx === 1'b1) reply_q.push_back(mon_byte);
        else                  tx_ferr++;
      end
    end
    mon_prev = uart_tx;
  end

  // Reference model at frame level. It gives the bus cycle the frame should
  // produce and the reply bytes, based only on the command semantics.
  bit          exp_txn;
  logic        exp_we;
  logic [31:0] exp_adr;
  logic [31:0] exp_dat;
  int          exp_len;
  logic [7:0]  exp_reply[$];

  function automatic void model_frame(input logic [7:0] fr[$], input bit acked,
                                      input int delay, input logic [31:0] rdata);
    exp_reply.delete();
    exp_txn = 1'b0;
    if (fr.size() < 5) return;
    if (fr[0] != 8'h57 && fr[0] != 8'h52) return;
    exp_we  = (fr[0] == 8'h57);
    if (exp_we && fr.size() < 9) return;
    exp_txn = 1'b1;
    exp_adr = {fr[1], fr[2], fr[3], fr[4]};
    exp_dat = exp_we ? {fr[5], fr[6], fr[7], fr[8]} : 32'h0;
    exp_len = acked ? delay + 1 : ATO;
    if (!acked)      exp_reply.push_back(8'h45);
    else if (exp_we) exp_reply.push_back(8'h4B);
    else for (int k = 3; k >= 0; k--) exp_reply.push_back(rdata[8*k +: 8]);
  endfunction

  // Stimulus helpers
  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    uart_rx = 1'b0;
    repeat (CPB) @(negedge wb_clk_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      repeat (CPB) @(negedge wb_clk_i);
    end
    uart_rx = stop_bit;
    repeat (CPB) @(negedge wb_clk_i);
    uart_rx = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] fr[$], input int max_gap);
    foreach (fr[i]) begin
      send_byte(fr[i], 1'b1);
      repeat ($urandom_range(0, max_gap)) @(negedge wb_clk_i);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (busy_o !== 1'b0 && n < 5000) begin
      @(negedge wb_clk_i);
      n++;
    end
    if (busy_o !== 1'b0) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_idle_timeout busy_o=%b after %0d cycles, required 0", name, busy_o, n);
    end
    repeat (4) @(negedge wb_clk_i);
  endtask

  task automatic clear_logs();
    txn_q.delete();
    reply_q.delete();
  endtask

  // Tests
  task automatic test_reset();
    wb_rst_i = 1'b1;
    uart_rx  = 1'b1;
    repeat (3) @(negedge wb_clk_i);
    checks++; if (uart_tx !== 1'b1)       begin errors++; $display("[TB] FAIL rst_tx got=%b want=1", uart_tx); end
    checks++; if (wbm_cyc_o !== 1'b0)     begin errors++; $display("[TB] FAIL rst_cyc got=%b want=0", wbm_cyc_o); end
    checks++; if (wbm_stb_o !== 1'b0)     begin errors++; $display("[TB] FAIL rst_stb got=%b want=0", wbm_stb_o); end
    checks++; if (wbm_we_o !== 1'b0)      begin errors++; $display("[TB] FAIL rst_we got=%b want=0", wbm_we_o); end
    checks++; if (wbm_sel_o !== 4'h0)     begin errors++; $display("[TB] FAIL rst_sel got=%h want=0", wbm_sel_o); end
    checks++; if (wbm_adr_o !== 32'h0)    begin errors++; $display("[TB] FAIL rst_adr got=%h want=0", wbm_adr_o); end
    checks++; if (wbm_dat_o !== 32'h0)    begin errors++; $display("[TB] FAIL rst_dat got=%h want=0", wbm_dat_o); end
    checks++; if (busy_o !== 1'b0)        begin errors++; $display("[TB] FAIL rst_busy got=%b want=0", busy_o); end
    wb_rst_i = 1'b0;
    repeat (5) @(negedge wb_clk_i);
  endtask

  task automatic test_write();
    logic [7:0] fr[$];
    fr = '{8'h57, 8'h30, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    clear_logs();
    ack_en = 1'b1; ack_delay = 3;
    model_frame(fr, 1'b1, 3, 32'h0);
    send_byte(fr[0], 1'b1);
    checks++; if (busy_o !== 1'b1) begin errors++; $display("[TB] FAIL wr_busy_high got=%b want=1", busy_o); end
    fr.pop_front();
    send_frame(fr, 2);
    wait_idle("wr");
    checks++; if (txn_q.size() !== 1) begin errors++; $display("[TB] FAIL wr_count got=%0d want=1", txn_q.size()); end
    if (txn_q.size() >= 1) begin
      checks++; if (txn_q[0].adr !== exp_adr) begin errors++; $display("[TB] FAIL wr_adr got=%h want=%h", txn_q[0].adr, exp_adr); end
      checks++; if (txn_q[0].dat !== exp_dat) begin errors++; $display("[TB] FAIL wr_dat got=%h want=%h", txn_q[0].dat, exp_dat); end
      checks++; if (txn_q[0].we !== 1'b1)     begin errors++; $display("[TB] FAIL wr_we got=%b want=1", txn_q[0].we); end
      checks++; if (txn_q[0].sel !== 4'hF)    begin errors++; $display("[TB] FAIL wr_sel got=%h want=F", txn_q[0].sel); end
      checks++; if (txn_q[0].len !== 4)       begin errors++; $display("[TB] FAIL wr_cyc_len got=%0d want=4", txn_q[0].len); end
      checks++; if (!txn_q[0].stable)         begin errors++; $display("[TB] FAIL wr_stable got=0 want=1"); end
    end
    checks++; if (reply_q.size() !== 1) begin errors++; $display("[TB] FAIL wr_reply_len got=%0d want=1", reply_q.size()); end
    if (reply_q.size() >= 1) begin
      checks++; if (reply_q[0] !== 8'h4B) begin errors++; $display("[TB] FAIL wr_reply got=%h want=4B", reply_q[0]); end
    end
    checks++; if (wbm_adr_o !== exp_adr) begin errors++; $display("[TB] FAIL wr_adr_hold got=%h want=%h", wbm_adr_o, exp_adr); end
  endtask

  task automatic test_read();
    logic [7:0] fr[$];
    fr = '{8'h52, 8'h30, 8'h00, 8'h00, 8'h04};
    clear_logs();
    ack_en = 1'b1; ack_delay = 1; slave_rdata = 32'h1234_5678;
    model_frame(fr, 1'b1, 1, slave_rdata);
    send_frame(fr, 2);
    wait_idle("rd");
    checks++; if (txn_q.size() !== 1) begin errors++; $display("[TB] FAIL rd_count got=%0d want=1", txn_q.size()); end
    if (txn_q.size() >= 1) begin
      checks++; if (txn_q[0].adr !== 32'h3000_0004) begin errors++; $display("[TB] FAIL rd_adr got=%h want=30000004", txn_q[0].adr); end
      checks++; if (txn_q[0].we !== 1'b0)   begin errors++; $display("[TB] FAIL rd_we got=%b want=0", txn_q[0].we); end
      checks++; if (txn_q[0].sel !== 4'hF)  begin errors++; $display("[TB] FAIL rd_sel got=%h want=F", txn_q[0].sel); end
      checks++; if (txn_q[0].len !== exp_len) begin errors++; $display("[TB] FAIL rd_cyc_len got=%0d want=%0d", txn_q[0].len, exp_len); end
    end
    checks++; if (reply_q.size() !== 4) begin errors++; $display("[TB] FAIL rd_reply_len got=%0d want=4", reply_q.size()); end
    for (int i = 0; i < 4 && i < reply_q.size(); i++) begin
      checks++; if (reply_q[i] !== exp_reply[i]) begin errors++; $display("[TB] FAIL rd_reply[%0d] got=%h want=%h", i, reply_q[i], exp_reply[i]); end
    end
  endtask

  task automatic test_random();
    logic [7:0]  fr[$];
    logic [31:0] a, d;
    bit          w;
    int          dl;
    for (int n = 0; n < 6; n++) begin
      a = $urandom; d = $urandom; w = 1'($urandom_range(0, 1)); dl = int'($urandom_range(0, 5));
      fr = w ? '{8'h57, a[31:24], a[23:16], a[15:8], a[7:0], d[31:24], d[23:16], d[15:8], d[7:0]}
             : '{8'h52, a[31:24], a[23:16], a[15:8], a[7:0]};
      clear_logs();
      ack_en = 1'b1; ack_delay = dl; slave_rdata = $urandom;
      model_frame(fr, 1'b1, dl, slave_rdata);
      send_frame(fr, 3);
      wait_idle("rnd");
      checks++; if (txn_q.size() !== 1) begin errors++; $display("[TB] FAIL rnd%0d_count got=%0d want=1", n, txn_q.size()); end
      if (txn_q.size() >= 1) begin
        checks++; if (txn_q[0].adr !== exp_adr) begin errors++; $display("[TB] FAIL rnd%0d_adr got=%h want=%h", n, txn_q[0].adr, exp_adr); end
        checks++; if (txn_q[0].we !== exp_we)   begin errors++; $display("[TB] FAIL rnd%0d_we got=%b want=%b", n, txn_q[0].we, exp_we); end
        checks++; if (txn_q[0].len !== exp_len) begin errors++; $display("[TB] FAIL rnd%0d_len got=%0d want=%0d", n, txn_q[0].len, exp_len); end
        if (exp_we) begin
          checks++; if (txn_q[0].dat !== exp_dat) begin errors++; $display("[TB] FAIL rnd%0d_dat got=%h want=%h", n, txn_q[0].dat, exp_dat); end
        end
      end
      checks++; if (reply_q.size() !== exp_reply.size()) begin errors++; $display("[TB] FAIL rnd%0d_reply_len got=%0d want=%0d", n, reply_q.size(), exp_reply.size()); end
      for (int i = 0; i < exp_reply.size() && i < reply_q.size(); i++) begin
        checks++; if (reply_q[i] !== exp_reply[i]) begin errors++; $display("[TB] FAIL rnd%0d_reply[%0d] got=%h want=%h", n, i, reply_q[i], exp_reply[i]); end
      end
    end
  endtask

  task automatic test_timeout();
    logic [7:0]  fr[$];
    logic [31:0] a;
    for (int n = 0; n < 2; n++) begin
      a = $urandom;
      fr = (n == 0) ? '{8'h57, a[31:24], a[23:16], a[15:8], a[7:0], 8'h11, 8'h22, 8'h33, 8'h44}
                    : '{8'h52, a[31:24], a[23:16], a[15:8], a[7:0]};
      clear_logs();
      ack_en = 1'b0;
      model_frame(fr, 1'b0, 0, 32'h0);
      send_frame(fr, 1);
      wait_idle("tmo");
      checks++; if (txn_q.size() !== 1) begin errors++; $display("[TB] FAIL tmo%0d_count got=%0d want=1", n, txn_q.size()); end
      if (txn_q.size() >= 1) begin
        checks++; if (txn_q[0].len !== exp_len) begin errors++; $display("[TB] FAIL tmo%0d_cyc_len got=%0d want=%0d", n, txn_q[0].len, exp_len); end
      end
      checks++; if (reply_q.size() !== 1) begin errors++; $display("[TB] FAIL tmo%0d_reply_len got=%0d want=1", n, reply_q.size()); end
      if (reply_q.size() >= 1) begin
        checks++; if (reply_q[0] !== 8'h45) begin errors++; $display("[TB] FAIL tmo%0d_reply got=%h want=45", n, reply_q[0]); end
      end
    end
    ack_en = 1'b1;
  endtask

  task automatic test_junk_framing();
    logic [7:0] fr[$];
    clear_logs();
    send_byte(8'hAA, 1'b1);
    repeat (4) @(negedge wb_clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL junk_busy got=%b want=0", busy_o); end
    repeat (CPB * 12) @(negedge wb_clk_i);
    checks++; if (reply_q.size() !== 0) begin errors++; $display("[TB] FAIL junk_reply got=%0d bytes want=0", reply_q.size()); end
    send_byte(8'h52, 1'b1);
    send_byte(8'h40, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h5A, 1'b0);
    repeat (CPB * 3) @(negedge wb_clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL ferr_busy got=%b want=0", busy_o); end
    checks++; if (txn_q.size() !== 0) begin errors++; $display("[TB] FAIL ferr_wb got=%0d cycles want=0", txn_q.size()); end
    fr = '{8'h52, 8'hA0, 8'h00, 8'h10, 8'h08};
    ack_en = 1'b1; ack_delay = 0; slave_rdata = 32'hCAFE_F00D;
    model_frame(fr, 1'b1, 0, slave_rdata);
    send_frame(fr, 1);
    wait_idle("ferr");
    checks++; if (txn_q.size() !== 1) begin errors++; $display("[TB] FAIL ferr_next_count got=%0d want=1", txn_q.size()); end
    if (txn_q.size() >= 1) begin
      checks++; if (txn_q[0].adr !== exp_adr) begin errors++; $display("[TB] FAIL ferr_next_adr got=%h want=%h", txn_q[0].adr, exp_adr); end
    end
    checks++; if (reply_q.size() !== 4) begin errors++; $display("[TB] FAIL ferr_next_reply_len got=%0d want=4", reply_q.size()); end
    for (int i = 0; i < 4 && i < reply_q.size(); i++) begin
      checks++; if (reply_q[i] !== exp_reply[i]) begin errors++; $display("[TB] FAIL ferr_next_reply[%0d] got=%h want=%h", i, reply_q[i], exp_reply[i]); end
    end
  endtask

  task automatic test_glitch();
    logic [7:0] fr[$];
    clear_logs();
    uart_rx = 1'b0;
    repeat (CPB / 4) @(negedge wb_clk_i);
    uart_rx = 1'b1;
    repeat (CPB * 12) @(negedge wb_clk_i);
    checks++; if (busy_o !== 1'b0) begin errors++; $display("[TB] FAIL glitch_busy got=%b want=0", busy_o); end
    checks++; if (reply_q.size() !== 0 || txn_q.size() !== 0) begin errors++; $display("[TB] FAIL glitch_activity got=%0d/%0d want=0/0", reply_q.size(), txn_q.size()); end
    fr = '{8'h57, 8'h00, 8'h00, 8'h00, 8'h10, 8'h01, 8'h02, 8'h03, 8'h04};
    ack_en = 1'b1; ack_delay = 2;
    model_frame(fr, 1'b1, 2, 32'h0);
    send_frame(fr, 0);
    wait_idle("glitch");
    checks++; if (txn_q.size() !== 1) begin errors++; $display("[TB] FAIL glitch_next_count got=%0d want=1", txn_q.size()); end
    if (txn_q.size() >= 1) begin
      checks++; if (txn_q[0].dat !== exp_dat) begin errors++; $display("[TB] FAIL glitch_next_dat got=%h want=%h", txn_q[0].dat, exp_dat); end
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] fr[$];
    int n;
    fr = '{8'h57, 8'h30, 8'h00, 8'h00, 8'h08, 8'h55, 8'h66, 8'h77, 8'h88};
    clear_logs();
    ack_en = 1'b0;
    send_frame(fr, 0);
    n = 0;
    while (wbm_cyc_o !== 1'b1 && n < 2000) begin
      @(negedge wb_clk_i);
      n++;
    end
    checks++; if (wbm_cyc_o !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_cyc_start got=%b want=1", wbm_cyc_o); end
    repeat (5) @(negedge wb_clk_i);
    wb_rst_i = 1'b1;
    @(negedge wb_clk_i);
    checks++; if (wbm_cyc_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_cyc got=%b want=0", wbm_cyc_o); end
    checks++; if (wbm_stb_o !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_stb got=%b want=0", wbm_stb_o); end
    checks++; if (uart_tx !== 1'b1)   begin errors++; $display("[TB] FAIL rstmid_tx got=%b want=1", uart_tx); end
    checks++; if (busy_o !== 1'b0)    begin errors++; $display("[TB] FAIL rstmid_busy got=%b want=0", busy_o); end
    wb_rst_i = 1'b0;
    repeat (5) @(negedge wb_clk_i);
    clear_logs();
    ack_en = 1'b1; ack_delay = 1;
    model_frame(fr, 1'b1, 1, 32'h0);
    send_frame(fr, 1);
    wait_idle("rstmid");
    checks++; if (txn_q.size() !== 1) begin errors++; $display("[TB] FAIL rstmid_next_count got=%0d want=1", txn_q.size()); end
    checks++; if (reply_q.size() !== 1 || reply_q[0] !== 8'h4B) begin errors++; $display("[TB] FAIL rstmid_next_reply got=%0d bytes want=1 byte 4B", reply_q.size()); end
  endtask

  initial begin
    wbm_ack_i = 1'b0;
    wbm_dat_i = '0;
    uart_rx   = 1'b1;
    wb_rst_i  = 1'b1;
    @(negedge wb_clk_i);
    test_reset();
    test_write();
    test_read();
    test_random();
    test_timeout();
    test_junk_framing();
    test_glitch();
    test_reset_mid();
    checks++; if (tx_ferr !== 0) begin errors++; $display("[TB] FAIL tx_stop_bits got=%0d bad want=0", tx_ferr); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

endmodule
